// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: ALU select codes, operand-source encodings
// and the forwarding-source enum used by the ID/EX stage.
package rv32_pipe_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SLL    = 5'b00001;
    localparam logic [4:0] ALU_SLT    = 5'b00010;
    localparam logic [4:0] ALU_SLTU   = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SRL    = 5'b00101;
    localparam logic [4:0] ALU_OR     = 5'b00110;
    localparam logic [4:0] ALU_AND    = 5'b00111;
    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;
    localparam logic [4:0] ALU_SUB    = 5'b10000;
    localparam logic [4:0] ALU_SRA    = 5'b10001;
    localparam logic [4:0] ALU_FWD    = 5'b11000;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_src_t;

endpackage

// File: rtl/id_ex_pipeline_stage_fwd_mux.sv
// Operand forwarding for one source register: MEM beats WB beats register data;
// x0 is never forwarded.
module fwd_mux
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] i_rs_addr,
    input  logic [XLEN-1:0] i_rs_data,
    input  logic            i_mem_wr,
    input  logic [RA_W-1:0] i_mem_addr,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_wb_wr,
    input  logic [RA_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_data
);

    logic     w_mem_hit;
    logic     w_wb_hit;
    fwd_src_t w_src;

    assign w_mem_hit = i_mem_wr && (i_mem_addr != '0) && (i_mem_addr == i_rs_addr);
    assign w_wb_hit  = i_wb_wr  && (i_wb_addr  != '0) && (i_wb_addr  == i_rs_addr);

    always_comb begin
        w_src = FWD_REG;
        if (w_mem_hit)
            w_src = FWD_MEM;
        else if (w_wb_hit)
            w_src = FWD_WB;
    end

    always_comb begin
        o_data = i_rs_data;
        case (w_src)
            FWD_MEM: o_data = i_mem_data;
            FWD_WB:  o_data = i_wb_data;
            default: o_data = i_rs_data;
        endcase
    end

endmodule

// File: rtl/id_ex_pipeline_stage.sv
// ID/EX pipeline register feeding the ALU: forwarding, load-use bubbles, stall/flush.
// Optional perf counters (BUBBLE_COUNT/HOLD_COUNT) under `ID_EX_PERF_CNT_EN.
module id_ex_pipeline_stage
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned SEL_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ID_VALID,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic [XLEN-1:0]  ID_RS1_DATA,
    input  logic [XLEN-1:0]  ID_RS2_DATA,
    input  logic [XLEN-1:0]  ID_IMM,
    input  logic [RA_W-1:0]  ID_RS1_ADDR,
    input  logic [RA_W-1:0]  ID_RS2_ADDR,
    input  logic [RA_W-1:0]  ID_RD_ADDR,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [SEL_W-1:0] ID_ALU_SELECT,
    input  logic             ID_OP1_SEL,
    input  logic             ID_OP2_SEL,
    input  logic             ID_MEM_READ,
    input  logic             ID_MEM_WRITE,
    input  logic             ID_REG_WRITE,
    input  logic             MEM_REG_WRITE,
    input  logic [RA_W-1:0]  MEM_RD_ADDR,
    input  logic [XLEN-1:0]  MEM_FWD_DATA,
    input  logic             WB_REG_WRITE,
    input  logic [RA_W-1:0]  WB_RD_ADDR,
    input  logic [XLEN-1:0]  WB_DATA,
    input  logic             FLUSH,
    input  logic             STALL_IN,
    output logic [XLEN-1:0]  ALU_DATA1,
    output logic [XLEN-1:0]  ALU_DATA2,
    output logic [SEL_W-1:0] ALU_SELECT,
    output logic [XLEN-1:0]  EX_STORE_DATA,
    output logic [XLEN-1:0]  EX_PC,
    output logic [RA_W-1:0]  EX_RD_ADDR,
    output logic             EX_VALID,
    output logic             EX_MEM_READ,
    output logic             EX_MEM_WRITE,
    output logic             EX_REG_WRITE,
    output logic             LOAD_USE_STALL
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]      BUBBLE_COUNT,
    output logic [31:0]      HOLD_COUNT
`endif
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [RA_W-1:0]  r_rs1_addr;
    logic [RA_W-1:0]  r_rs2_addr;
    logic [RA_W-1:0]  r_rd_addr;
    logic [SEL_W-1:0] r_alu_sel;
    logic             r_op1_sel;
    logic             r_op2_sel;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_reg_write;

    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;
    logic             w_load_use;
    logic             w_bubble;

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .i_rs_addr (r_rs1_addr),
        .i_rs_data (r_rs1_data),
        .i_mem_wr  (MEM_REG_WRITE),
        .i_mem_addr(MEM_RD_ADDR),
        .i_mem_data(MEM_FWD_DATA),
        .i_wb_wr   (WB_REG_WRITE),
        .i_wb_addr (WB_RD_ADDR),
        .i_wb_data (WB_DATA),
        .o_data    (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .i_rs_addr (r_rs2_addr),
        .i_rs_data (r_rs2_data),
        .i_mem_wr  (MEM_REG_WRITE),
        .i_mem_addr(MEM_RD_ADDR),
        .i_mem_data(MEM_FWD_DATA),
        .i_wb_wr   (WB_REG_WRITE),
        .i_wb_addr (WB_RD_ADDR),
        .i_wb_data (WB_DATA),
        .o_data    (w_fwd_rs2)
    );

    assign w_load_use = r_valid && r_mem_read && (r_rd_addr != '0) && ID_VALID &&
                        ((ID_USES_RS1 && (ID_RS1_ADDR == r_rd_addr)) ||
                         (ID_USES_RS2 && (ID_RS2_ADDR == r_rd_addr)));
    assign w_bubble   = FLUSH || w_load_use;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET || (!STALL_IN && w_bubble)) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_alu_sel   <= '0;
            r_op1_sel   <= 1'b0;
            r_op2_sel   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (STALL_IN) begin
            // Capture forwarded operands while held so a retiring WB value survives.
            r_rs1_data  <= w_fwd_rs1;
            r_rs2_data  <= w_fwd_rs2;
        end else begin
            r_valid     <= ID_VALID;
            r_pc        <= ID_PC;
            r_rs1_data  <= ID_RS1_DATA;
            r_rs2_data  <= ID_RS2_DATA;
            r_imm       <= ID_IMM;
            r_rs1_addr  <= ID_RS1_ADDR;
            r_rs2_addr  <= ID_RS2_ADDR;
            r_rd_addr   <= ID_RD_ADDR;
            r_alu_sel   <= ID_ALU_SELECT;
            r_op1_sel   <= ID_OP1_SEL;
            r_op2_sel   <= ID_OP2_SEL;
            r_mem_read  <= ID_MEM_READ  && ID_VALID;
            r_mem_write <= ID_MEM_WRITE && ID_VALID;
            r_reg_write <= ID_REG_WRITE && ID_VALID;
        end
    end

    assign ALU_DATA1      = (r_op1_sel == OP1_PC)  ? r_pc  : w_fwd_rs1;
    assign ALU_DATA2      = (r_op2_sel == OP2_IMM) ? r_imm : w_fwd_rs2;
    assign ALU_SELECT     = r_alu_sel;
    assign EX_STORE_DATA  = w_fwd_rs2;
    assign EX_PC          = r_pc;
    assign EX_RD_ADDR     = r_rd_addr;
    assign EX_VALID       = r_valid;
    assign EX_MEM_READ    = r_mem_read;
    assign EX_MEM_WRITE   = r_mem_write;
    assign EX_REG_WRITE   = r_reg_write;
    assign LOAD_USE_STALL = w_load_use;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_hold_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else if (STALL_IN) begin
            if (r_hold_cnt != '1)
                r_hold_cnt <= r_hold_cnt + 32'd1;
        end else if (w_bubble) begin
            if (r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign BUBBLE_COUNT = r_bubble_cnt;
    assign HOLD_COUNT   = r_hold_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_stage.sv
// Self-checking bench for id_ex_pipeline_stage: directed scenarios then random
// traffic against a behavioural model of the EX-side instruction.
module tb_id_ex_pipeline_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ID_VALID;
    logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
    logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
    logic        ID_USES_RS1, ID_USES_RS2;
    logic [4:0]  ID_ALU_SELECT;
    logic        ID_OP1_SEL, ID_OP2_SEL;
    logic        ID_MEM_READ, ID_MEM_WRITE, ID_REG_WRITE;
    logic        MEM_REG_WRITE;
    logic [4:0]  MEM_RD_ADDR;
    logic [31:0] MEM_FWD_DATA;
    logic        WB_REG_WRITE;
    logic [4:0]  WB_RD_ADDR;
    logic [31:0] WB_DATA;
    logic        FLUSH, STALL_IN;
    logic [31:0] ALU_DATA1, ALU_DATA2, EX_STORE_DATA, EX_PC;
    logic [4:0]  ALU_SELECT, EX_RD_ADDR;
    logic        EX_VALID, EX_MEM_READ, EX_MEM_WRITE, EX_REG_WRITE;
    logic        LOAD_USE_STALL;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] BUBBLE_COUNT, HOLD_COUNT;
`endif

    id_ex_pipeline_stage #(.XLEN(32), .RA_W(5), .SEL_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .ID_ALU_SELECT(ID_ALU_SELECT),
        .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL), .ID_MEM_READ(ID_MEM_READ),
        .ID_MEM_WRITE(ID_MEM_WRITE), .ID_REG_WRITE(ID_REG_WRITE),
        .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_FWD_DATA(MEM_FWD_DATA),
        .WB_REG_WRITE(WB_REG_WRITE), .WB_RD_ADDR(WB_RD_ADDR), .WB_DATA(WB_DATA),
        .FLUSH(FLUSH), .STALL_IN(STALL_IN),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
        .EX_STORE_DATA(EX_STORE_DATA), .EX_PC(EX_PC), .EX_RD_ADDR(EX_RD_ADDR),
        .EX_VALID(EX_VALID), .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
        .EX_REG_WRITE(EX_REG_WRITE), .LOAD_USE_STALL(LOAD_USE_STALL)
`ifdef ID_EX_PERF_CNT_EN
        , .BUBBLE_COUNT(BUBBLE_COUNT), .HOLD_COUNT(HOLD_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Instruction as seen in EX, in architectural terms.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rs1, rs2, rd, op;
        logic        use_pc, use_imm, ld, st, wr;
    } ex_instr_t;

    ex_instr_t   m;
    int unsigned exp_bubbles, exp_holds;
    int unsigned n_pass = 0, n_fail = 0, n_total = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Newest producer of a register, as seen by the instruction in EX.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] held);
        if (r == 5'd0)                            return held;
        if (MEM_REG_WRITE && MEM_RD_ADDR == r)    return MEM_FWD_DATA;
        if (WB_REG_WRITE && WB_RD_ADDR == r)      return WB_DATA;
        return held;
    endfunction

    function automatic logic needs_loaded_value();
        if (!(m.valid && m.ld && m.rd != 5'd0 && ID_VALID)) return 1'b0;
        return (ID_USES_RS1 && ID_RS1_ADDR == m.rd) || (ID_USES_RS2 && ID_RS2_ADDR == m.rd);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, EX_VALID}, {31'd0, m.valid});
        chk({tag, ".ld"},    {31'd0, EX_MEM_READ}, {31'd0, m.ld});
        chk({tag, ".st"},    {31'd0, EX_MEM_WRITE}, {31'd0, m.st});
        chk({tag, ".wr"},    {31'd0, EX_REG_WRITE}, {31'd0, m.wr});
        chk({tag, ".sel"},   {27'd0, ALU_SELECT}, {27'd0, m.op});
        chk({tag, ".lus"},   {31'd0, LOAD_USE_STALL}, {31'd0, needs_loaded_value()});
        if (m.valid) begin
            chk({tag, ".pc"},    EX_PC, m.pc);
            chk({tag, ".rd"},    {27'd0, EX_RD_ADDR}, {27'd0, m.rd});
            chk({tag, ".a"},     ALU_DATA1, m.use_pc ? m.pc : operand(m.rs1, m.rs1v));
            chk({tag, ".b"},     ALU_DATA2, m.use_imm ? m.imm : operand(m.rs2, m.rs2v));
            chk({tag, ".store"}, EX_STORE_DATA, operand(m.rs2, m.rs2v));
        end
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, ".bubbles"}, BUBBLE_COUNT, exp_bubbles);
        chk({tag, ".holds"},   HOLD_COUNT, exp_holds);
`endif
    endtask

    task automatic tick();
        ex_instr_t nx;
        nx = m;
        if (STALL_IN) begin
            nx.rs1v = operand(m.rs1, m.rs1v);
            nx.rs2v = operand(m.rs2, m.rs2v);
            exp_holds = exp_holds + 1;
        end else if (FLUSH || needs_loaded_value()) begin
            nx = '0;
            exp_bubbles = exp_bubbles + 1;
        end else begin
            nx.valid = ID_VALID;     nx.pc = ID_PC;
            nx.rs1v = ID_RS1_DATA;   nx.rs2v = ID_RS2_DATA;   nx.imm = ID_IMM;
            nx.rs1 = ID_RS1_ADDR;    nx.rs2 = ID_RS2_ADDR;    nx.rd = ID_RD_ADDR;
            nx.op = ID_ALU_SELECT;   nx.use_pc = ID_OP1_SEL;  nx.use_imm = ID_OP2_SEL;
            nx.ld = ID_MEM_READ & ID_VALID;
            nx.st = ID_MEM_WRITE & ID_VALID;
            nx.wr = ID_REG_WRITE & ID_VALID;
        end
        @(posedge CLK);
        m = nx;
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                         input logic [4:0] op);
        ID_VALID = 1'b1; ID_PC = pc; ID_RS1_ADDR = r1; ID_RS1_DATA = d1;
        ID_RS2_ADDR = r2; ID_RS2_DATA = d2; ID_RD_ADDR = rd; ID_ALU_SELECT = op;
        ID_IMM = 32'h0000_0ABC; ID_USES_RS1 = 1'b1; ID_USES_RS2 = 1'b1;
        ID_OP1_SEL = 1'b0; ID_OP2_SEL = 1'b0;
        ID_MEM_READ = 1'b0; ID_MEM_WRITE = 1'b0; ID_REG_WRITE = 1'b1;
    endtask

    task automatic quiet_fwd();
        MEM_REG_WRITE = 1'b0; MEM_RD_ADDR = '0; MEM_FWD_DATA = '0;
        WB_REG_WRITE = 1'b0;  WB_RD_ADDR = '0;  WB_DATA = '0;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; STALL_IN = 1'b0;
        issue(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        ID_VALID = 1'b0; ID_REG_WRITE = 1'b0; ID_IMM = '0;
        quiet_fwd();
        m = '0; exp_bubbles = 0; exp_holds = 0;

        // Reset state
        #12;
        chk("rst.valid", {31'd0, EX_VALID}, 32'd0);
        chk("rst.sel",   {27'd0, ALU_SELECT}, 32'd0);
        chk("rst.a",     ALU_DATA1, 32'd0);
        chk("rst.b",     ALU_DATA2, 32'd0);
        chk("rst.lus",   {31'd0, LOAD_USE_STALL}, 32'd0);
        RESET = 1'b0;

        // ADD x3,x1,x2
        issue(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'b00000);
        #1 tick();
        ID_VALID = 1'b0;
        #1;
        chk("add.a", ALU_DATA1, 32'd5);
        chk("add.b", ALU_DATA2, 32'd7);
        chk("add.valid", {31'd0, EX_VALID}, 32'd1);
        check_all("add");

        // Forwarding priority MEM > WB > register, x0 never forwarded
        issue(32'h104, 5'd4, 32'h99, 5'd2, 32'd1, 5'd5, 5'b10000);
        #1 tick();
        MEM_REG_WRITE = 1'b1; MEM_RD_ADDR = 5'd4; MEM_FWD_DATA = 32'h11;
        WB_REG_WRITE = 1'b1;  WB_RD_ADDR = 5'd4;  WB_DATA = 32'h22;
        #1 chk("fwd.mem", ALU_DATA1, 32'h11);
        MEM_REG_WRITE = 1'b0;
        #1 chk("fwd.wb", ALU_DATA1, 32'h22);
        issue(32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'b00000);
        #1 tick();
        MEM_REG_WRITE = 1'b1; MEM_RD_ADDR = 5'd0; MEM_FWD_DATA = 32'h33;
        WB_RD_ADDR = 5'd0; WB_DATA = 32'h44;
        #1 chk("fwd.x0", ALU_DATA1, 32'h0);
        check_all("fwd.x0");
        quiet_fwd();

        // Load-use: LW x6 in EX, ADD reading x6 via rs2 in ID
        issue(32'h10C, 5'd1, 32'd0, 5'd0, 32'd0, 5'd6, 5'b00000);
        ID_MEM_READ = 1'b1;
        #1 tick();
        issue(32'h110, 5'd1, 32'd3, 5'd6, 32'd0, 5'd7, 5'b00000);
        #1 chk("lu.stall", {31'd0, LOAD_USE_STALL}, 32'd1);
        tick();
        chk("lu.bubble.valid", {31'd0, EX_VALID}, 32'd0);
        chk("lu.bubble.wr", {31'd0, EX_REG_WRITE}, 32'd0);
        check_all("lu.after");

        // STALL_IN for 3 cycles while WB retires x9 = 0xDEAD
        issue(32'h200, 5'd9, 32'h0, 5'd2, 32'd8, 5'd10, 5'b00100);
        #1 tick();
        issue(32'h204, 5'd11, 32'd1, 5'd12, 32'd2, 5'd13, 5'b00001);
        STALL_IN = 1'b1;
        WB_REG_WRITE = 1'b1; WB_RD_ADDR = 5'd9; WB_DATA = 32'hDEAD;
        #1 tick();
        quiet_fwd();
        #1 check_all("stall.1");
        tick();
        #1 check_all("stall.2");
        tick();
        chk("stall.pc", EX_PC, 32'h200);
        chk("stall.sel", {27'd0, ALU_SELECT}, {27'd0, 5'b00100});
        STALL_IN = 1'b0;
        #1 chk("stall.release", ALU_DATA1, 32'hDEAD);
        check_all("stall.release");
        tick();
        check_all("stall.next");

        // FLUSH alone, then FLUSH with STALL_IN
        issue(32'h300, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 5'b10001);
        FLUSH = 1'b1;
        #1 tick();
        chk("flush.valid", {31'd0, EX_VALID}, 32'd0);
        chk("flush.sel", {27'd0, ALU_SELECT}, 32'd0);
        chk("flush.wr", {31'd0, EX_REG_WRITE}, 32'd0);
        FLUSH = 1'b0;
        #1 tick();
        FLUSH = 1'b1; STALL_IN = 1'b1;
        #1 tick();
        tick();
        chk("flush.stall.held", {31'd0, EX_VALID}, 32'd1);
        STALL_IN = 1'b0;
        #1 tick();
        chk("flush.stall.bubble", {31'd0, EX_VALID}, 32'd0);
        FLUSH = 1'b0;
        #1 check_all("flush.done");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            issue($urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
                  $urandom, 5'($urandom_range(0, 7)), 5'($urandom));
            ID_VALID = ($urandom_range(0, 9) != 0);
            ID_IMM = $urandom;
            ID_USES_RS1 = 1'($urandom); ID_USES_RS2 = 1'($urandom);
            ID_OP1_SEL = 1'($urandom);  ID_OP2_SEL = 1'($urandom);
            ID_MEM_READ = ($urandom_range(0, 2) == 0);
            ID_MEM_WRITE = 1'($urandom); ID_REG_WRITE = 1'($urandom);
            MEM_REG_WRITE = 1'($urandom); MEM_RD_ADDR = 5'($urandom_range(0, 7));
            MEM_FWD_DATA = $urandom;
            WB_REG_WRITE = 1'($urandom);  WB_RD_ADDR = 5'($urandom_range(0, 7));
            WB_DATA = $urandom;
            FLUSH = ($urandom_range(0, 9) == 0);
            STALL_IN = ($urandom_range(0, 5) == 0);
            #1 check_all("rand");
            tick();
        end
        FLUSH = 1'b0; STALL_IN = 1'b0; quiet_fwd();

        // Asynchronous reset between edges
        issue(32'h400, 5'd1, 32'd9, 5'd2, 32'd9, 5'd3, 5'b00111);
        #1 tick();
        #2 RESET = 1'b1;
        #1;
        m = '0; exp_bubbles = 0; exp_holds = 0;
        chk("arst.valid", {31'd0, EX_VALID}, 32'd0);
        chk("arst.a", ALU_DATA1, 32'd0);
        chk("arst.sel", {27'd0, ALU_SELECT}, 32'd0);
        chk("arst.lus", {31'd0, LOAD_USE_STALL}, 32'd0);
        check_all("arst");
        #1 RESET = 1'b0;

        // Two bubbles (flush, load-use) and three held cycles
        FLUSH = 1'b1;
        #1 tick();
        FLUSH = 1'b0;
        ID_MEM_READ = 1'b1; ID_RD_ADDR = 5'd6;
        #1 tick();
        issue(32'h404, 5'd6, 32'd0, 5'd0, 32'd0, 5'd7, 5'b00000);
        #1 tick();
        STALL_IN = 1'b1;
        #1 tick();
        tick();
        tick();
        STALL_IN = 1'b0;
        #1 check_all("perf");
`ifdef ID_EX_PERF_CNT_EN
        chk("perf.bubbles", BUBBLE_COUNT, 32'd2);
        chk("perf.holds", HOLD_COUNT, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
